// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, padding parameters and helper types.
// Imported by the padder, its block generator and the compression core.
package sha256_pkg;

    localparam int SHA256_BLOCK_BITS     = 512;
    localparam int SHA256_LEN_FIELD_BITS = 64;
    localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;

    localparam logic [255:0] SHA256_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // K[0] occupies the top 32 bits
    localparam logic [2047:0] SHA256_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic {
        PAD_IDLE,
        PAD_EMIT
    } pad_state_t;

    function automatic int pad_nblocks(input int len);
        return (len + SHA256_LEN_FIELD_BITS / 8) / 64 + 1;
    endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Message-in / padded-block-out handshake bundle for the SHA-256 padder.
// slave = padder side, master = producer/consumer side.
interface sha256_msg_padder_if #(
    parameter int MAX_BYTES = 80
);
    import sha256_pkg::*;

    localparam int LEN_W      = $clog2(MAX_BYTES + 1);
    localparam int MAX_BLOCKS = (MAX_BYTES + 8) / 64 + 1;
    localparam int BLK_W      = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

    logic                         msg_valid;
    logic                         msg_ready;
    logic [MAX_BYTES*8-1:0]       msg_data;
    logic [LEN_W-1:0]             msg_len;
    logic                         blk_valid;
    logic                         blk_ready;
    logic [SHA256_BLOCK_BITS-1:0] blk_data;
    logic [BLK_W-1:0]             blk_idx;
    logic                         blk_first;
    logic                         blk_last;
    logic                         len_err;

    modport slave (
        input  msg_valid, msg_data, msg_len, blk_ready,
        output msg_ready, blk_valid, blk_data, blk_idx,
        output blk_first, blk_last, len_err
    );

    modport master (
        output msg_valid, msg_data, msg_len, blk_ready,
        input  msg_ready, blk_valid, blk_data, blk_idx,
        input  blk_first, blk_last, len_err
    );

endinterface

// File: rtl/sha256_pad_block_gen.sv
// Combinational builder of one FIPS 180-4 padded block from a
// left-aligned message, its byte length and the block index.
module sha256_pad_block_gen
    import sha256_pkg::*;
#(
    parameter int MAX_BYTES = 80,
    parameter int LEN_W     = 7,
    parameter int BLK_W     = 1,
    parameter int NB_W      = 2
) (
    input  logic [MAX_BYTES*8-1:0]       msg,
    input  logic [LEN_W-1:0]             len,
    input  logic [BLK_W-1:0]             blk_idx,
    input  logic [NB_W-1:0]              nblocks,
    output logic [SHA256_BLOCK_BITS-1:0] blk
);

    logic [63:0] bitlen;
    logic        last;
    logic [7:0]  b;
    int          g;

    always_comb begin
        bitlen = 64'(len) << 3;
        last   = (int'(blk_idx) == int'(nblocks) - 1);
        blk    = '0;
        b      = 8'h00;
        g      = 0;
        for (int j = 0; j < 64; j++) begin
            g = int'(blk_idx) * 64 + j;
            b = 8'h00;
            if (g < int'(len) && g < MAX_BYTES) begin
                b = msg[(MAX_BYTES-1-g)*8 +: 8];
            end else if (g == int'(len)) begin
                b = SHA256_PAD_BYTE;
            end
            if (last && j >= 56) begin
                b = bitlen[(63-j)*8 +: 8];
            end
            blk[(63-j)*8 +: 8] = b;
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: captures one message, then streams its
// padded 512-bit blocks back-to-back to the compression core.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int MAX_BYTES = 80
) (
    input  logic                clk,
    input  logic                rst,
    sha256_msg_padder_if.slave  bus
);

    localparam int LEN_W      = $clog2(MAX_BYTES + 1);
    localparam int MAX_BLOCKS = (MAX_BYTES + 8) / 64 + 1;
    localparam int BLK_W      = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
    localparam int NB_W       = $clog2(MAX_BLOCKS + 1);

    pad_state_t                   state;
    logic [MAX_BYTES*8-1:0]       msg_q;
    logic [LEN_W-1:0]             len_q;
    logic [NB_W-1:0]              nblk_q;
    logic [BLK_W-1:0]             idx_q;
    logic [SHA256_BLOCK_BITS-1:0] data_q;
    logic                         valid_q;
    logic                         first_q;
    logic                         last_q;
    logic                         ready_q;
    logic                         err_q;

    logic [MAX_BYTES*8-1:0]       g_msg;
    logic [LEN_W-1:0]             g_len;
    logic [BLK_W-1:0]             g_idx;
    logic [NB_W-1:0]              g_nb;
    logic [SHA256_BLOCK_BITS-1:0] g_blk;

    logic [NB_W-1:0]  nb_in;
    logic [BLK_W-1:0] next_idx;
    logic             accept;
    logic             len_ok;
    logic             xfer;

    assign nb_in    = NB_W'(pad_nblocks(int'(bus.msg_len)));
    assign next_idx = idx_q + 1'b1;
    assign len_ok   = int'(bus.msg_len) <= MAX_BYTES;
    assign accept   = bus.msg_valid && ready_q && (state == PAD_IDLE);
    assign xfer     = valid_q && bus.blk_ready;

    // In IDLE the generator looks at the live input so block 0 is
    // ready to register on the capture edge.
    always_comb begin
        g_msg = bus.msg_data;
        g_len = bus.msg_len;
        g_idx = '0;
        g_nb  = nb_in;
        if (state == PAD_EMIT) begin
            g_msg = msg_q;
            g_len = len_q;
            g_idx = next_idx;
            g_nb  = nblk_q;
        end
    end

    sha256_pad_block_gen #(
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W),
        .BLK_W     (BLK_W),
        .NB_W      (NB_W)
    ) u_gen (
        .msg     (g_msg),
        .len     (g_len),
        .blk_idx (g_idx),
        .nblocks (g_nb),
        .blk     (g_blk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PAD_IDLE;
            msg_q   <= '0;
            len_q   <= '0;
            nblk_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                PAD_IDLE: begin
                    if (accept && !len_ok) begin
                        err_q <= 1'b1;
                    end else if (accept) begin
                        msg_q   <= bus.msg_data;
                        len_q   <= bus.msg_len;
                        nblk_q  <= nb_in;
                        idx_q   <= '0;
                        data_q  <= g_blk;
                        valid_q <= 1'b1;
                        first_q <= 1'b1;
                        last_q  <= (nb_in == NB_W'(1));
                        ready_q <= 1'b0;
                        state   <= PAD_EMIT;
                    end
                end
                PAD_EMIT: begin
                    if (xfer && last_q) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= PAD_IDLE;
                    end else if (xfer) begin
                        idx_q   <= next_idx;
                        data_q  <= g_blk;
                        first_q <= 1'b0;
                        last_q  <= (int'(next_idx) == int'(nblk_q) - 1);
                    end
                end
                default: state <= PAD_IDLE;
            endcase
        end
    end

    assign bus.msg_ready = ready_q;
    assign bus.blk_valid = valid_q;
    assign bus.blk_data  = data_q;
    assign bus.blk_idx   = idx_q;
    assign bus.blk_first = first_q;
    assign bus.blk_last  = last_q;
    assign bus.len_err   = err_q;

endmodule
